lm32_tlb_refill: RTL and testbench

- Hardware refill engine that writes the instruction TLB.
- On an ITLB miss it fetches the page-table entry over a Wishbone master port from a single-level linear page table, then issues a one-cycle update (tlbvaddr/tlbpaddr/update) to the ITLB.
- Invalid PTEs and bus errors are reported as a fault for the exception logic.
- Sits between the core's miss signalling, the page-table base CSR and the instruction bus arbiter.

---
 rtl/lm32_tlb_refill_if.sv | 20 ++
 rtl/lm32_tlb_refill.sv | 204 ++++++++++++++++++++
 tb/tb_lm32_tlb_refill.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/lm32_tlb_refill_if.sv
// Wishbone master port of the ITLB refill engine: PTE fetch address, strobes and response.
interface lm32_tlb_refill_if;
  logic [31:0] wb_adr_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_adr_o, wb_cyc_o, wb_stb_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_adr_o, wb_cyc_o, wb_stb_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/lm32_tlb_refill.sv
// ITLB refill engine: fetches one PTE from a linear page table and writes the ITLB.
// Optional bus timeout fault is enabled by defining CFG_REFILL_TIMEOUT_EN.
module lm32_tlb_refill #(
  parameter int unsigned page_size      = 4096,
  parameter int unsigned timeout_cycles = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        miss_req,
  input  logic [31:0] miss_vaddr,
  input  logic [31:0] ptbr,
  input  logic        abort,
  output logic        ack,
  output logic        busy,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] tlbvaddr,
  output logic [31:0] tlbpaddr,
  output logic        update,
  lm32_tlb_refill_if.master wb
);

  localparam int page_bits = $clog2(page_size);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  state_t      state_r, state_d;
  logic [31:0] vaddr_r, vaddr_d;
  logic [31:0] adr_r, adr_d;
  logic        cyc_r, cyc_d;
  logic        busy_r, busy_d;
  logic        ack_r, ack_d;
  logic        update_r, update_d;
  logic        fault_r, fault_d;
  logic [1:0]  cause_r, cause_d;
  logic [31:0] tlbv_r, tlbv_d;
  logic [31:0] tlbp_r, tlbp_d;
  logic        aborted_r, aborted_d;
  logic [31:0] pte_off_s;
  logic        unused_pte_s;

`ifdef CFG_REFILL_TIMEOUT_EN
  localparam int cnt_w = ($clog2(timeout_cycles + 1) > 8) ? $clog2(timeout_cycles + 1) : 8;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(timeout_cycles - 1);
  localparam logic [cnt_w-1:0] cnt_one  = {{(cnt_w-1){1'b0}}, 1'b1};
  logic [cnt_w-1:0] cnt_r, cnt_d;
`else
  localparam int unsigned unused_timeout_cycles = timeout_cycles;
`endif

  // PTE offset: vpn scaled by 4 bytes per entry; the add wraps modulo 2^32.
  assign pte_off_s    = (miss_vaddr >> page_bits) << 2'd2;
  assign unused_pte_s = ^wb.wb_dat_i[page_bits-1:1];

  // Next-state and next-output logic of the walk sequencer.
  always_comb begin
    state_d   = state_r;
    vaddr_d   = vaddr_r;
    adr_d     = adr_r;
    cyc_d     = cyc_r;
    busy_d    = busy_r;
    ack_d     = 1'b0;
    update_d  = 1'b0;
    fault_d   = 1'b0;
    cause_d   = cause_r;
    tlbv_d    = tlbv_r;
    tlbp_d    = tlbp_r;
    aborted_d = aborted_r;
`ifdef CFG_REFILL_TIMEOUT_EN
    cnt_d     = cnt_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (miss_req && !abort) begin
          state_d   = ST_FETCH;
          vaddr_d   = miss_vaddr;
          adr_d     = ptbr + pte_off_s;
          cyc_d     = 1'b1;
          busy_d    = 1'b1;
          aborted_d = 1'b0;
`ifdef CFG_REFILL_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // An abort seen in any FETCH cycle turns the completion into a silent ack.
        aborted_d = aborted_r | abort;
        if (wb.wb_err_i) begin
          cyc_d = 1'b0;
          ack_d = 1'b1;
          if (aborted_d) begin
            state_d = ST_UPDATE;
          end else begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            cause_d = 2'b10;
          end
        end else if (wb.wb_ack_i) begin
          cyc_d = 1'b0;
          ack_d = 1'b1;
          if (aborted_d) begin
            state_d = ST_UPDATE;
          end else if (wb.wb_dat_i[0]) begin
            state_d  = ST_UPDATE;
            update_d = 1'b1;
            tlbv_d   = vaddr_r;
            tlbp_d   = {wb.wb_dat_i[31:page_bits], vaddr_r[page_bits-1:0]};
          end else begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            cause_d = 2'b01;
          end
        end else begin
`ifdef CFG_REFILL_TIMEOUT_EN
          if (cnt_r == cnt_last) begin
            cyc_d = 1'b0;
            ack_d = 1'b1;
            if (aborted_d) begin
              state_d = ST_UPDATE;
            end else begin
              state_d = ST_FAULT;
              fault_d = 1'b1;
              cause_d = 2'b11;
            end
          end else begin
            cnt_d = cnt_r + cnt_one;
          end
`else
          state_d = ST_FETCH;
`endif
        end
      end
      ST_UPDATE, ST_FAULT: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output register bank; reset drops any bus cycle at once.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r   <= ST_IDLE;
      vaddr_r   <= 32'h0000_0000;
      adr_r     <= 32'h0000_0000;
      cyc_r     <= 1'b0;
      busy_r    <= 1'b0;
      ack_r     <= 1'b0;
      update_r  <= 1'b0;
      fault_r   <= 1'b0;
      cause_r   <= 2'b00;
      tlbv_r    <= 32'h0000_0000;
      tlbp_r    <= 32'h0000_0000;
      aborted_r <= 1'b0;
`ifdef CFG_REFILL_TIMEOUT_EN
      cnt_r     <= '0;
`endif
    end else begin
      state_r   <= state_d;
      vaddr_r   <= vaddr_d;
      adr_r     <= adr_d;
      cyc_r     <= cyc_d;
      busy_r    <= busy_d;
      ack_r     <= ack_d;
      update_r  <= update_d;
      fault_r   <= fault_d;
      cause_r   <= cause_d;
      tlbv_r    <= tlbv_d;
      tlbp_r    <= tlbp_d;
      aborted_r <= aborted_d;
`ifdef CFG_REFILL_TIMEOUT_EN
      cnt_r     <= cnt_d;
`endif
    end
  end

  // A late abort still cancels the ITLB write or fault in the completion cycle.
  assign update      = update_r & ~abort;
  assign fault       = fault_r & ~abort;
  assign ack         = ack_r;
  assign busy        = busy_r;
  assign fault_cause = cause_r;
  assign tlbvaddr    = tlbv_r;
  assign tlbpaddr    = tlbp_r;

  assign wb.wb_adr_o = adr_r;
  assign wb.wb_cyc_o = cyc_r;
  assign wb.wb_stb_o = cyc_r;
  assign wb.wb_sel_o = 4'hF;

endmodule

// File: tb/tb_lm32_tlb_refill.sv
// Self-checking bench for lm32_tlb_refill: directed walks plus random walks against a page-table model.
module tb_lm32_tlb_refill;
  localparam logic [31:0] PAGE = 32'd4096;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        miss_req = 1'b0;
  logic [31:0] miss_vaddr = 32'h0;
  logic [31:0] ptbr = 32'h0;
  logic        abort = 1'b0;
  logic        ack, busy, fault, update;
  logic [1:0]  fault_cause;
  logic [31:0] tlbvaddr, tlbpaddr;

  int checks = 0;
  int errors = 0;
  string cur_tag = "reset";

  logic [31:0] exp_tlbv = 32'h0;
  logic [31:0] exp_tlbp = 32'h0;
  logic [1:0]  exp_cause = 2'b00;

  always #5 clk_i = ~clk_i;

  lm32_tlb_refill_if bus ();

  lm32_tlb_refill #(.page_size(4096), .timeout_cycles(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .miss_req    (miss_req),
    .miss_vaddr  (miss_vaddr),
    .ptbr        (ptbr),
    .abort       (abort),
    .ack         (ack),
    .busy        (busy),
    .fault       (fault),
    .fault_cause (fault_cause),
    .tlbvaddr    (tlbvaddr),
    .tlbpaddr    (tlbpaddr),
    .update      (update),
    .wb          (bus)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%h expected=%h", cur_tag, name, obs, exp);
    end
  endtask

  task automatic check_idle_outputs();
    check("ack", 32'(ack), 32'd0);
    check("busy", 32'(busy), 32'd0);
    check("update", 32'(update), 32'd0);
    check("fault", 32'(fault), 32'd0);
    check("cyc", 32'(bus.wb_cyc_o), 32'd0);
  endtask

  // One complete walk; the model derives address, translation and result from the page-table rules.
  task automatic walk(input logic [31:0] va, input logic [31:0] base, input logic [31:0] pte,
                      input int waits, input bit err, input int abort_at, input bit abort_last);
    int          lat;
    logic [31:0] exp_adr;
    bit          aborted, exp_upd, exp_flt;
    exp_adr = base + (va / PAGE) * 32'd4;
    aborted = (abort_at >= 0);
    miss_req = 1'b1; miss_vaddr = va; ptbr = base; abort = 1'b0;
    lat = 0;
    @(negedge clk_i); lat++;
    check("adr", bus.wb_adr_o, exp_adr);
    check("busy_fetch", 32'(busy), 32'd1);
    check("sel", 32'(bus.wb_sel_o), 32'hF);
    for (int k = 0; k <= waits; k++) begin
      abort = (k == abort_at);
      bus.wb_ack_i = (k == waits);
      bus.wb_err_i = (k == waits) && err;
      bus.wb_dat_i = (k == waits) ? pte : $urandom;
      check("cyc_held", 32'(bus.wb_cyc_o & bus.wb_stb_o), 32'd1);
      @(negedge clk_i); lat++;
    end
    bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; abort = 1'b0;
    exp_upd = !aborted && !err && pte[0] && !abort_last;
    exp_flt = !aborted && (err || !pte[0]) && !abort_last;
    if (!aborted && err) exp_cause = 2'b10;
    else if (!aborted && !pte[0]) exp_cause = 2'b01;
    else exp_cause = exp_cause;
    if (!aborted && !err && pte[0]) begin
      exp_tlbv = va;
      exp_tlbp = (pte & ~(PAGE - 32'd1)) | (va & (PAGE - 32'd1));
    end
    if (abort_last) begin
      abort = 1'b1;
      #1;
    end
    check("ack", 32'(ack), 32'd1);
    check("latency", 32'(lat), 32'(waits + 2));
    check("cyc_dropped", 32'(bus.wb_cyc_o), 32'd0);
    check("update", 32'(update), 32'(exp_upd));
    check("fault", 32'(fault), 32'(exp_flt));
    check("cause", 32'(fault_cause), 32'(exp_cause));
    check("tlbvaddr", tlbvaddr, exp_tlbv);
    check("tlbpaddr", tlbpaddr, exp_tlbp);
    miss_req = 1'b0;
    @(negedge clk_i);
    abort = 1'b0;
    check_idle_outputs();
  endtask

  initial begin
    logic [31:0] r, b, p;
    int w, ab;
    bit e;
    bus.wb_dat_i = 32'h0; bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0;
    #2;
    check_idle_outputs();
    check("cause", 32'(fault_cause), 32'd0);
    check("adr", bus.wb_adr_o, 32'd0);
    check("tlbvaddr", tlbvaddr, 32'd0);
    check("tlbpaddr", tlbpaddr, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);

    cur_tag = "valid";   walk(32'h0000_5ABC, 32'h0010_0000, 32'h8003_0001, 0, 1'b0, -1, 1'b0);
    cur_tag = "invalid"; walk(32'h0000_5ABC, 32'h0010_0000, 32'h8003_0000, 0, 1'b0, -1, 1'b0);
    cur_tag = "buserr";  walk(32'h0000_5ABC, 32'h0010_0000, 32'h8003_0001, 2, 1'b1, -1, 1'b0);
    cur_tag = "abort";   walk(32'h0000_5ABC, 32'h0010_0000, 32'h8003_0001, 4, 1'b0, 0, 1'b0);
    cur_tag = "wrap";    walk(32'h0000_8000, 32'hFFFF_FFF0, 32'h1234_5001, 1, 1'b0, -1, 1'b0);
    cur_tag = "abort_upd"; walk(32'h7654_3210, 32'h0020_0000, 32'hABCD_E001, 0, 1'b0, -1, 1'b1);

    cur_tag = "idle_abort";
    miss_req = 1'b1; abort = 1'b1;
    @(negedge clk_i);
    miss_req = 1'b0; abort = 1'b0;
    check_idle_outputs();

    for (int i = 0; i < 16; i++) begin
      cur_tag = $sformatf("rand%0d", i);
      r = $urandom;
      b = r & 32'hFFFF_FFFC;
      p = $urandom;
      w = int'($urandom_range(0, 3));
      e = ($urandom_range(0, 7) == 0);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, w)) : -1;
      walk($urandom, b, p, w, e, ab, 1'b0);
    end

`ifdef CFG_REFILL_TIMEOUT_EN
    cur_tag = "timeout";
    miss_req = 1'b1; miss_vaddr = 32'h0000_3000; ptbr = 32'h0001_0000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      check("cyc_wait", 32'(bus.wb_cyc_o), 32'd1);
    end
    @(negedge clk_i);
    miss_req = 1'b0;
    check("cyc_dropped", 32'(bus.wb_cyc_o), 32'd0);
    check("ack", 32'(ack), 32'd1);
    check("fault", 32'(fault), 32'd1);
    check("cause", 32'(fault_cause), 32'd3);
    exp_cause = 2'b11;
    bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hFFFF_F001;
    @(negedge clk_i);
    bus.wb_ack_i = 1'b0;
    check_idle_outputs();
    check("tlbvaddr", tlbvaddr, exp_tlbv);
`endif

    cur_tag = "reset_mid";
    miss_req = 1'b1; miss_vaddr = 32'h0000_9000; ptbr = 32'h0040_0000;
    @(negedge clk_i);
    check("cyc_fetch", 32'(bus.wb_cyc_o), 32'd1);
    #2 rst_i = 1'b0;
    #1;
    check_idle_outputs();
    check("adr", bus.wb_adr_o, 32'd0);
    check("cause", 32'(fault_cause), 32'd0);
    check("tlbvaddr", tlbvaddr, 32'd0);
    check("tlbpaddr", tlbpaddr, 32'd0);
    miss_req = 1'b0;
    bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h0005_0001;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check_idle_outputs();
    bus.wb_ack_i = 1'b0;
    @(negedge clk_i);
    check_idle_outputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
